icache_direct: RTL and testbench

- Direct-mapped, one-word-block instruction cache between the pipelined datapath's fetch port and the memory controller.
- Consumes the fetch address and read request from the datapath's fetch stage. Returns the instruction word and a hit strobe.
- On a miss, issues a single-word read to memory and fills the line.

---
 rtl/icache_direct.sv | 154 +++++++++++++++
 tb/tb_icache_direct.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_direct.sv
// icache_direct: direct-mapped instruction cache with one-word lines, between the
// fetch stage and the memory controller. A lookup hits in the same cycle it is asked.
// On a miss the cache reads one word from memory and writes it into the line.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   imemREN, imemaddr    fetch request and byte address from the datapath
//   ihit, imemload       hit strobe and instruction word (imemload is 0 when there is no hit)
//   iflush               clears every valid bit at the clock edge
//   iREN, iaddr          single-word read request and word address to memory
//   iwait, iload         memory busy flag; while iwait is low, iload holds the read data
//   hit_count,           saturating statistics counters; these ports exist only when
//   miss_count           ICACHE_STATS_EN is defined
//
// Optional feature macro: ICACHE_STATS_EN
module icache_direct #(
  parameter int unsigned SETS      = 16,
  parameter int unsigned RESET_TAG = 0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDXW = $clog2(SETS);
  localparam int unsigned TAGW = 30 - IDXW;

  typedef enum logic [0:0] {StIdle, StFill} state_e;

  state_e            state_q;
  logic [29:0]       miss_word_q;  // word address of the line being filled
  logic [SETS-1:0]   valid_q;
  logic [TAGW-1:0]   tag_q  [SETS];
  logic [31:0]       data_q [SETS];

  logic [IDXW-1:0]   req_idx;
  logic [TAGW-1:0]   req_tag;
  logic [IDXW-1:0]   fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              lookup_hit;
  logic              miss_det;
  logic              fill_done;

  // The byte offset plays no part in the lookup.
  logic unused_addr_bits;
  assign unused_addr_bits = ^imemaddr[1:0];

  assign req_idx  = imemaddr[IDXW+1:2];
  assign req_tag  = imemaddr[31:IDXW+2];
  assign fill_idx = miss_word_q[IDXW-1:0];
  assign fill_tag = miss_word_q[29:IDXW];

  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss_det   = (state_q == StIdle) && imemREN && !lookup_hit;
  assign fill_done  = (state_q == StFill) && !iwait;

  always_comb begin
    ihit     = 1'b0;
    imemload = '0;
    iREN     = 1'b0;
    iaddr    = '0;
    if (state_q == StIdle) begin
      ihit = imemREN && lookup_hit;
      if (ihit) begin
        imemload = data_q[req_idx];
      end
    end else begin
      // iREN comes from the state register alone, so reset drops it at once.
      iREN  = 1'b1;
      iaddr = {miss_word_q, 2'b00};
    end
  end

  // Control FSM. While a fill is in progress, fetch redirects and stalls are ignored.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= StIdle;
      miss_word_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (miss_det) begin
            miss_word_q <= imemaddr[31:2];
            state_q     <= StFill;
          end
        end
        StFill: begin
          if (!iwait) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Line storage: one write port (the fill) and one combinational read port.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      for (int i = 0; i < int'(SETS); i++) begin
        tag_q[i]  <= TAGW'(RESET_TAG);
        data_q[i] <= '0;
      end
    end else begin
      if (fill_done) begin
        data_q[fill_idx] <= iload;
        tag_q[fill_idx]  <= fill_tag;
      end
      // A flush in the same cycle as fill completion leaves the new line invalid.
      if (iflush) begin
        valid_q <= '0;
      end else if (fill_done) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      if (ihit && (hit_count_q != 32'hFFFF_FFFF)) begin
        hit_count_q <= hit_count_q + 32'd1;
      end
      if (miss_det && (miss_count_q != 32'hFFFF_FFFF)) begin
        miss_count_q <= miss_count_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct. The stimulus pushes the expected instruction words into
// hit_q and the expected fill addresses into fill_q. A monitor pops them and compares
// each time the DUT raises ihit or finishes a memory read.
module tb_icache_direct;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iflush;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] hit_q  [$];
  logic [31:0] fill_q [$];

  icache_direct #(
    .SETS      (16),
    .RESET_TAG (0)
  ) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iflush    (iflush),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents, fixed by hand.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0040: return 32'h2001_0005;
      32'h0000_0044: return 32'h2002_0006;
      32'h0000_0080: return 32'h8C00_0010;
      32'h0000_0100: return 32'h0000_1234;
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign iload = mem_word(iaddr);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One fetch. On a miss the memory holds iwait high for nwait cycles. If fl_wait is set,
  // iflush is pulsed during the first of those wait cycles.
  task automatic fetch(input logic [31:0] a, input int nwait, input bit miss,
                       input logic [31:0] w, input bit fl_wait);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    hit_q.push_back(w);
    @(negedge CLK);
    check("first_cycle_ihit", 32'(ihit), miss ? 32'd0 : 32'd1);
    if (miss) begin
      fill_q.push_back(a);
      step();
      for (int k = 0; k < nwait; k++) begin
        iflush = fl_wait && (k == 0);
        @(negedge CLK);
        check("fill_iren", 32'(iREN), 32'd1);
        check("fill_iaddr", iaddr, a);
        step();
      end
      iflush = 1'b0;
      iwait  = 1'b0;
      @(negedge CLK);
      check("fill_iren", 32'(iREN), 32'd1);
      check("fill_iaddr", iaddr, a);
      step();
      iwait = 1'b1;
    end
    step();
  endtask

  // Monitor: pops the scoreboard queues whenever the DUT produces a response.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (nRST) begin
        if (ihit) begin
          if (hit_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_ihit: got imemload=%h required no hit at %0t",
                     imemload, $time);
          end else begin
            e = hit_q.pop_front();
            check("imemload", imemload, e);
          end
        end else begin
          check("imemload_zero_without_hit", imemload, 32'd0);
        end
        if (iREN && !iwait) begin
          if (fill_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_fill: got iaddr=%h required no fill at %0t",
                     iaddr, $time);
          end else begin
            e = fill_q.pop_front();
            check("fill_addr", iaddr, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "timeout");
  end

  initial begin
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iflush   = 1'b0;
    iwait    = 1'b1;
    #1;
    check("rst_ihit", 32'(ihit), 32'd0);
    check("rst_iren", 32'(iREN), 32'd0);
    check("rst_iaddr", iaddr, 32'd0);
    check("rst_imemload", imemload, 32'd0);
    repeat (2) @(posedge CLK);
    #1 nRST = 1'b1;
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    check("rst_hit_count", hit_count, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);
    step();
`endif

    // Basic miss, then a hit on the same address.
    fetch(32'h40, 0, 1'b1, 32'h2001_0005, 1'b0);
    fetch(32'h40, 0, 1'b0, 32'h2001_0005, 1'b0);

    // Conflict on index 0.
    fetch(32'h80, 0, 1'b1, 32'h8C00_0010, 1'b0);
    fetch(32'h80, 0, 1'b0, 32'h8C00_0010, 1'b0);
    fetch(32'h40, 0, 1'b1, 32'h2001_0005, 1'b0);
    fetch(32'h40, 0, 1'b0, 32'h2001_0005, 1'b0);

    // A redirect and a stall during a long fill are both ignored.
    fetch(32'h80, 0, 1'b1, 32'h8C00_0010, 1'b0);
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    fill_q.push_back(32'h40);
    @(negedge CLK);
    check("redirect_first_ihit", 32'(ihit), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      imemaddr = 32'h100;
      imemREN  = (k != 2);
      @(negedge CLK);
      check("redirect_iren", 32'(iREN), 32'd1);
      check("redirect_iaddr", iaddr, 32'h40);
      step();
    end
    imemREN  = 1'b1;
    imemaddr = 32'h40;
    iwait    = 1'b0;
    @(negedge CLK);
    step();
    iwait = 1'b1;
    hit_q.push_back(32'h2001_0005);
    @(negedge CLK);
    check("redirect_line_valid", 32'(ihit), 32'd1);
    step();
    fetch(32'h100, 0, 1'b1, 32'h0000_1234, 1'b0);

    // Flush pulse: the lookup in the flush cycle still sees the old valid bits.
    fetch(32'h40, 0, 1'b1, 32'h2001_0005, 1'b0);
    fetch(32'h44, 0, 1'b1, 32'h2002_0006, 1'b0);
    imemaddr = 32'h44;
    iflush   = 1'b1;
    hit_q.push_back(32'h2002_0006);
    @(negedge CLK);
    check("flush_cycle_ihit", 32'(ihit), 32'd1);
    step();
    iflush = 1'b0;
    fetch(32'h40, 0, 1'b1, 32'h2001_0005, 1'b0);
    fetch(32'h44, 0, 1'b1, 32'h2002_0006, 1'b0);

    // A flush while iwait is high does not stop the line from becoming valid.
    fetch(32'h80, 2, 1'b1, 32'h8C00_0010, 1'b1);
    fetch(32'h80, 0, 1'b0, 32'h8C00_0010, 1'b0);

    // A flush in the same cycle the fill completes leaves the line invalid.
    imemREN  = 1'b1;
    imemaddr = 32'h44;
    fill_q.push_back(32'h44);
    @(negedge CLK);
    check("flushfill_first_ihit", 32'(ihit), 32'd0);
    step();
    iwait  = 1'b0;
    iflush = 1'b1;
    @(negedge CLK);
    step();
    iwait  = 1'b1;
    iflush = 1'b0;
    fetch(32'h44, 0, 1'b1, 32'h2002_0006, 1'b0);

    // Reset in the middle of a fill.
    imemREN  = 1'b1;
    imemaddr = 32'h48;
    @(negedge CLK);
    check("rstfill_first_ihit", 32'(ihit), 32'd0);
    step();
    step();
    check("rstfill_iren_before", 32'(iREN), 32'd1);
    #2 nRST = 1'b0;
    #1;
    check("rstfill_iren", 32'(iREN), 32'd0);
    check("rstfill_ihit", 32'(ihit), 32'd0);
    check("rstfill_iaddr", iaddr, 32'd0);
    imemREN = 1'b0;
    @(posedge CLK);
    #1 nRST = 1'b1;

    // The next block gives 3 misses and 7 hits.
    fetch(32'h44, 0, 1'b1, 32'h2002_0006, 1'b0);
    fetch(32'h40, 1, 1'b1, 32'h2001_0005, 1'b0);
    fetch(32'h40, 0, 1'b0, 32'h2001_0005, 1'b0);
    fetch(32'h44, 0, 1'b0, 32'h2002_0006, 1'b0);
    fetch(32'h80, 0, 1'b1, 32'h8C00_0010, 1'b0);
    fetch(32'h80, 0, 1'b0, 32'h8C00_0010, 1'b0);
    fetch(32'h44, 0, 1'b0, 32'h2002_0006, 1'b0);
    imemREN = 1'b0;
`ifdef ICACHE_STATS_EN
    @(negedge CLK);
    check("stats_hit_count", hit_count, 32'd7);
    check("stats_miss_count", miss_count, 32'd3);
    step();
    iflush = 1'b1;
    step();
    iflush = 1'b0;
    @(negedge CLK);
    check("stats_hit_after_flush", hit_count, 32'd7);
    check("stats_miss_after_flush", miss_count, 32'd3);
`endif
    step();
    step();
    check("hit_queue_drained", 32'(hit_q.size()), 32'd0);
    check("fill_queue_drained", 32'(fill_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
